// File: rtl/argmax_pkg.sv
// Shared constants and helpers for the streaming argmax classifier.
// Sizing helpers are functions so each instance derives its own widths.
package argmax_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_N     = 1;
  localparam int DEF_NOUT  = 4;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int BEATS  = DEF_NOUT / DEF_N;
  localparam int IDX_W  = clog2_min1(DEF_NOUT);
  localparam int BEAT_W = clog2_min1(BEATS);

  // Most negative two's complement value of width w, right-aligned in 64 bits.
  function automatic logic [63:0] MOST_NEG(input int w);
    return 64'(1) << (w - 1);
  endfunction

  // Callers sign-extend operands to 64 bits before calling.
  function automatic logic sgt(input logic signed [63:0] a, input logic signed [63:0] b);
    return a > b;
  endfunction
endpackage

// File: rtl/argmax_classifier_chunk.sv
// Combinational N-lane signed max; ties resolve to the lowest lane.
module chunk_argmax
  import argmax_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int N      = 1,
  parameter int LANE_W = 1
) (
  input  logic [WIDTH*N-1:0] act,
  output logic [WIDTH-1:0]   max_val,
  output logic [LANE_W-1:0]  max_lane
);
  always_comb begin
    max_val  = act[WIDTH-1:0];
    max_lane = '0;
    // Strict compare keeps the earlier lane on equal values.
    for (int j = 1; j < N; j++) begin
      if (sgt(64'($signed(act[WIDTH*j +: WIDTH])), 64'($signed(max_val)))) begin
        max_val  = act[WIDTH*j +: WIDTH];
        max_lane = LANE_W'(j);
      end
    end
  end
endmodule

// File: rtl/argmax_classifier.sv
// Streaming argmax over NOUT neurons delivered N per beat, with ideal-index check.
// Optional saturating accuracy counters: ARGMAX_ACCURACY_COUNTER_EN.
module argmax_classifier
  import argmax_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N     = 1,
  parameter  int NOUT  = 4,
  parameter  int CNT_W = 16,
  localparam int IW    = clog2_min1(NOUT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               act_valid,
  input  logic [WIDTH*N-1:0] act_in,
  input  logic [N-1:0]       y_in,
  output logic               result_valid,
  output logic [NOUT-1:0]    pred_onehot,
  output logic [IW-1:0]      pred_idx,
  output logic               correct,
  output logic               y_none,
  output logic [CNT_W-1:0]   sample_count,
  output logic [CNT_W-1:0]   correct_count
);
  localparam int NB = NOUT / N;
  localparam int BW = clog2_min1(NB);
  localparam int LW = clog2_min1(N);
  localparam logic [WIDTH-1:0] MNEG = WIDTH'(MOST_NEG(WIDTH));

  logic [BW-1:0]    beat;
  logic [WIDTH-1:0] run_max;
  logic [IW-1:0]    run_pos, y_idx;
  logic             y_seen;

  logic [WIDTH-1:0] c_max, m_max;
  logic [LW-1:0]    c_lane;
  logic [IW-1:0]    base, y_off, m_pos, m_yidx;
  logic             first, last, accept, fin, y_hit, m_yany, m_correct;

  chunk_argmax #(.WIDTH(WIDTH), .N(N), .LANE_W(LW)) u_chunk (
    .act     (act_in),
    .max_val (c_max),
    .max_lane(c_lane)
  );

  assign first  = (beat == '0);
  assign last   = (beat == BW'(NB - 1));
  assign accept = act_valid & ~clear;
  assign fin    = accept & last;
  assign base   = IW'(beat) * IW'(N);

  // Running state merged with the current beat, so the final beat needs no extra cycle.
  always_comb begin
    y_hit = |y_in;
    y_off = '0;
    for (int j = N - 1; j >= 0; j--)
      if (y_in[j]) y_off = IW'(j);
    if (first || sgt(64'($signed(c_max)), 64'($signed(run_max)))) begin
      m_max = c_max;
      m_pos = base + IW'(c_lane);
    end else begin
      m_max = run_max;
      m_pos = run_pos;
    end
    m_yany    = y_seen | y_hit;
    m_yidx    = y_seen ? y_idx : base + y_off;
    m_correct = m_yany && (m_pos == m_yidx);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat         <= '0;
      run_max      <= MNEG;
      run_pos      <= '0;
      y_seen       <= 1'b0;
      y_idx        <= '0;
      result_valid <= 1'b0;
      pred_onehot  <= NOUT'(1);
      pred_idx     <= '0;
      correct      <= 1'b0;
      y_none       <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (clear || fin) begin
        beat    <= '0;
        run_max <= MNEG;
        run_pos <= '0;
        y_seen  <= 1'b0;
        y_idx   <= '0;
      end else if (accept) begin
        beat    <= beat + 1'b1;
        run_max <= m_max;
        run_pos <= m_pos;
        y_seen  <= m_yany;
        y_idx   <= m_yidx;
      end
      if (fin) begin
        result_valid <= 1'b1;
        pred_onehot  <= NOUT'(1) << m_pos;
        pred_idx     <= m_pos;
        correct      <= m_correct;
        y_none       <= ~m_yany;
      end
    end
  end

`ifdef ARGMAX_ACCURACY_COUNTER_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_count  <= '0;
      correct_count <= '0;
    end else if (fin) begin
      if (~&sample_count) sample_count <= sample_count + 1'b1;
      if (m_correct && ~&correct_count) correct_count <= correct_count + 1'b1;
    end
  end
`else
  assign sample_count  = '0;
  assign correct_count = '0;
`endif
endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench: N=1/NOUT=4 instance for most cases, N=2/NOUT=8 for multi-lane.
module tb_argmax_classifier;
  import argmax_pkg::*;
`ifdef ARGMAX_ACCURACY_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        clr0 = 0, vld0 = 0;
  logic [15:0] act0 = '0;
  logic [0:0]  y0 = '0;
  logic        rv0, corr0, yn0;
  logic [3:0]  oh0;
  logic [1:0]  idx0;
  logic [15:0] sc0, cc0;

  logic        clr1 = 0, vld1 = 0;
  logic [31:0] act1 = '0;
  logic [1:0]  y1 = '0;
  logic        rv1, corr1, yn1;
  logic [7:0]  oh1;
  logic [2:0]  idx1;
  logic [15:0] sc1, cc1;

  argmax_classifier #(.WIDTH(16), .N(1), .NOUT(4), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .clear(clr0), .act_valid(vld0), .act_in(act0), .y_in(y0),
    .result_valid(rv0), .pred_onehot(oh0), .pred_idx(idx0), .correct(corr0), .y_none(yn0),
    .sample_count(sc0), .correct_count(cc0));

  argmax_classifier #(.WIDTH(16), .N(2), .NOUT(8), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .clear(clr1), .act_valid(vld1), .act_in(act1), .y_in(y1),
    .result_valid(rv1), .pred_onehot(oh1), .pred_idx(idx1), .correct(corr1), .y_none(yn1),
    .sample_count(sc1), .correct_count(cc1));

  int checks = 0, failures = 0, n_rv1 = 0;

  always @(negedge clk) if (rv1) n_rv1++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic b0(input logic [15:0] a, input logic y, input logic c);
    act0 = a; y0 = y; vld0 = 1'b1; clr0 = c;
    @(posedge clk); #1;
    vld0 = 1'b0; clr0 = 1'b0; y0 = '0;
  endtask

  task automatic b1(input logic [31:0] a, input logic [1:0] y);
    act1 = a; y1 = y; vld1 = 1'b1;
    @(posedge clk); #1;
    vld1 = 1'b0; y1 = '0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic chk_res0(input string tag, input logic [1:0] idx, input logic c, input logic yn);
    chk({tag, "_rv"}, 64'(rv0), 64'(1));
    chk({tag, "_idx"}, 64'(idx0), 64'(idx));
    chk({tag, "_oh"}, 64'(oh0), 64'(4'b0001 << idx));
    chk({tag, "_corr"}, 64'(corr0), 64'(c));
    chk({tag, "_ynone"}, 64'(yn0), 64'(yn));
  endtask

  initial begin
    @(posedge clk); #1;
    chk("rst_rv", 64'(rv0), 64'(0));
    chk("rst_oh", 64'(oh0), 64'(1));
    chk("rst_idx", 64'(idx0), 64'(0));
    chk("rst_corr", 64'(corr0), 64'(0));
    chk("rst_ynone", 64'(yn0), 64'(0));
    chk("rst_sc", 64'(sc0), 64'(0));
    reset = 1'b1;
    idle();

    // basic sample
    b0(16'h0100, 0, 0); b0(16'h0400, 1, 0); b0(16'hFF00, 0, 0);
    chk("basic_early", 64'(rv0), 64'(0));
    b0(16'h0200, 0, 0);
    chk_res0("basic", 2'd1, 1'b1, 1'b0);
    idle();
    chk("basic_pulse", 64'(rv0), 64'(0));
    chk("basic_hold", 64'(idx0), 64'(1));

    // equal negative values: lowest index wins
    b0(16'h8001, 0, 0); b0(16'h8001, 0, 0); b0(16'h8001, 0, 0); b0(16'h8001, 1, 0);
    chk_res0("tie", 2'd0, 1'b0, 1'b0);

    // back-to-back, signed ordering, first ideal bit latched
    b0(16'hFFFF, 1, 0); b0(16'h8000, 0, 0); b0(16'hFFFE, 0, 0); b0(16'h0000, 1, 0);
    chk_res0("signed", 2'd3, 1'b0, 1'b0);

    // clear wins over a coincident beat
    b0(16'h0700, 1, 0); b0(16'h0100, 0, 0); b0(16'h7FFF, 0, 1);
    chk("clr_rv", 64'(rv0), 64'(0));
    chk("clr_hold", 64'(idx0), 64'(3));
    b0(16'h0001, 0, 0); b0(16'h0002, 0, 0); b0(16'h0005, 1, 0);
    chk("clr_early", 64'(rv0), 64'(0));
    b0(16'h0003, 0, 0);
    chk_res0("clr_new", 2'd2, 1'b1, 1'b0);

    // no ideal bit
    b0(16'h0001, 0, 0); b0(16'h0002, 0, 0); b0(16'h0003, 0, 0); b0(16'h0004, 0, 0);
    chk_res0("noy", 2'd3, 1'b0, 1'b1);
    idle();
    chk("cnt_samples", 64'(sc0), CNT_EN ? 64'(5) : 64'(0));
    chk("cnt_correct", 64'(cc0), CNT_EN ? 64'(2) : 64'(0));

    // reset mid-sample
    b0(16'h0009, 0, 0); b0(16'h0009, 0, 0);
    reset = 1'b0;
    #2;
    chk("mrst_rv", 64'(rv0), 64'(0));
    chk("mrst_oh", 64'(oh0), 64'(1));
    chk("mrst_idx", 64'(idx0), 64'(0));
    chk("mrst_corr", 64'(corr0), 64'(0));
    chk("mrst_ynone", 64'(yn0), 64'(0));
    chk("mrst_sc", 64'(sc0), 64'(0));
    chk("mrst_cc", 64'(cc0), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    b0(16'h0001, 0, 0); b0(16'h0009, 1, 0);
    chk("mrst_b1", 64'(rv0), 64'(0));
    b0(16'h0002, 0, 0);
    chk("mrst_b2", 64'(rv0), 64'(0));
    b0(16'h0003, 0, 0);
    chk_res0("mrst_new", 2'd1, 1'b1, 1'b0);

    // multi-lane with gaps: neurons 5,9,9,3,1,1,0,7 -> index 1
    n_rv1 = 0;
    b1({16'd9, 16'd5}, 2'b10); idle();
    b1({16'd3, 16'd9}, 2'b00); idle();
    chk("ml_gap", 64'(rv1), 64'(0));
    b1({16'd1, 16'd1}, 2'b00); idle();
    b1({16'd7, 16'd0}, 2'b01);
    chk("ml_rv", 64'(rv1), 64'(1));
    chk("ml_idx", 64'(idx1), 64'(1));
    chk("ml_oh", 64'(oh1), 64'(8'h02));
    chk("ml_corr", 64'(corr1), 64'(1));
    chk("ml_ynone", 64'(yn1), 64'(0));
    idle(); idle();
    chk("ml_pulses", 64'(n_rv1), 64'(1));
    chk("ml_sc", 64'(sc1), CNT_EN ? 64'(1) : 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/argmax_classifier.md
# argmax_classifier

Streaming argmax and classification-check block for the DNN output layer. It accepts the output-layer activations in chunks of `N` neurons per clock and tracks the running signed maximum across one sample of `NOUT` neurons. At the end of each sample it registers a one-hot prediction, the predicted index, and a correct/incorrect flag against the ideal-output chunks that stream alongside. It replaces the fixed inline max-tracking logic at the network top with a parametrised, handshaken, resynchronisable block.

## Interface
- `WIDTH`, 16: activation bit width, two's complement.
- `N`, 1: neurons presented per beat; must be ≥1 and a power of 2.
- `NOUT`, 4: output neurons per sample; must be a multiple of `N`.
- `CNT_W`, 16: accuracy counter width.
- `clk`, input, 1: clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `clear`, input, 1: synchronous abort of the current sample.
- `act_valid`, input, 1: beat qualifier.
- `act_in`, input, `WIDTH*N`: activations; neuron `j` of the beat is `act_in[WIDTH*j +: WIDTH]`.
- `y_in`, input, `N`: ideal-output bits for the same `N` neurons.
- `result_valid`, output, 1: one-clock pulse when the result registers update.
- `pred_onehot`, output, `NOUT`: one-hot of the predicted class.
- `pred_idx`, output, `$clog2(NOUT)` (min 1): index of the predicted class.
- `correct`, output, 1: the predicted index equals the ideal index.
- `y_none`, output, 1: no ideal bit was set anywhere in the sample.
- `sample_count`, output, `CNT_W`: samples completed.
- `correct_count`, output, `CNT_W`: samples with `correct`=1.

## Operation
- **Beat counter.** `beat` runs 0..`NOUT/N`-1. It advances only on an accepted beat (`act_valid`=1, `clear`=0) and wraps to 0 after the last beat.
- **Chunk argmax.** Each beat, compute the signed max of the `N` activations and its lane index. Ties go to the lowest lane.
- **Running max.**
  - Beat 0 loads the chunk max directly.
  - Later beats replace the running max only when the chunk max is strictly greater, so ties keep the earlier (lower) neuron index.
  - The stored position is `beat*N + lane`.
- **Ideal index.** The index of the lowest set `y_in` bit seen in the sample is latched. Later set bits are ignored. If no bit is set by the final beat, `y_none`=1 and `correct`=0.
- **Final beat.** On the final beat, the result is computed from the running state merged with the current beat, so no extra clock is needed. The block then:
  - registers `pred_idx`, `pred_onehot`, `correct` and `y_none`;
  - pulses `result_valid`;
  - clears the running state for the next sample.
- **Result hold.** Result outputs hold their values until the next sample completes.
- **`clear`.**
  - Returns the beat counter, running max, position and ideal latch to their initial values. The running max initialises to the most negative value `{1'b1,{WIDTH-1{1'b0}}}`.
  - Leaves the result outputs and counters untouched.
  - If `clear` and `act_valid` are high together, `clear` wins and the beat is discarded.
- **Gaps.** `act_valid`=0 gaps mid-sample are legal. State holds through them.

## Timing
- **Latency.** If the final beat is sampled at edge k, `result_valid`=1 for the cycle after edge k, and the new results are visible from that same cycle.
- **Throughput.** One beat per clock with no stall. Back-to-back samples are supported: beat 0 of the next sample may arrive at edge k+1.
- **Reset.** While `reset`=0:
  - all outputs are 0, except `pred_onehot`=1 (class 0) and `pred_idx`=0;
  - the beat counter is 0;
  - the running max is the most negative value.
- **Mid-sample reset.** Asserting `reset` mid-sample aborts the sample with no `result_valid`.
- **`NOUT`=`N`.** Every accepted beat is both first and last, so `result_valid` follows every beat.

## Configuration
- `ARGMAX_ACCURACY_COUNTER_EN` defined:
  - on each result, `sample_count` increments by 1;
  - `correct_count` increments by 1 when `correct`=1;
  - both counters saturate at all-ones and are reset only by `reset`.
- Macro undefined: `sample_count` and `correct_count` are tied to 0 and no counter flops are synthesised. The ports remain.

## Structure
- **Package `argmax_pkg`:**
  - localparams: beats per sample, index width, beat-counter width;
  - a `MOST_NEG(WIDTH)` constant;
  - a signed greater-than function shared by the tree and the running stage.
- **Sub-module `chunk_argmax`:** combinational `N`-lane signed max tree with lowest-lane tie-break, outputs `{max, lane}`. The top holds the counter, running registers, ideal latch, result registers and counters.

## Test plan
- **Basic sample.** `WIDTH`=16, `N`=1, `NOUT`=4; beats 0x0100, 0x0400, 0xFF00, 0x0200 with `y_in`=0,1,0,0 → `result_valid` one cycle after beat 3, `pred_idx`=1, `pred_onehot`=4'b0010, `correct`=1.
- **Signed values and ties.** All four activations are 0x8001, and activation 2 is also 0x8001 → `pred_idx`=0 (lowest index wins, values treated as negative), with `y_in` bit 3 set → `correct`=0.
- **Multi-lane and gaps.** `N`=2, `NOUT`=8; beats (5,9),(9,3),(1,1),(0,7) with `act_valid`=0 gaps between beats → `pred_idx`=1, and the result pulses exactly once.
- **Clear mid-sample.** Assert `clear` together with `act_valid` on beat 2 → that beat is discarded. A fresh 4-beat sample then produces a result reflecting only the new sample, and the previous results are held until then.
- **No ideal bit.** All `y_in` bits are 0 → `y_none`=1, `correct`=0.
- **Counters and reset.** With the macro defined, 3 samples (2 correct) → `sample_count`=3, `correct_count`=2. Assert `reset` low mid-sample → all outputs at reset values, and no `result_valid` appears after release until a full new sample has been presented.
